// File: rtl/vedacao_ctrl.sv
// Capping-station controller: seals the bottle held at the sealing position,
// tracks the cap magazine and requests refills through a req/ack handshake.
module vedacao_ctrl #(
  parameter int SEAL_CYC = 4,
  parameter int CAP_MAX  = 15,
  parameter int LOW_MARK = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pos_ve,
  input  logic       refill_ack,
  output logic       ve_act,
  output logic       ve_done,
  output logic       refill_req,
  output logic       cap_low,
  output logic       cap_empty,
  output logic [7:0] cap_cnt,
  output logic [7:0] seal_total
);

  localparam logic [7:0] CAP_FULL   = 8'(CAP_MAX);
  localparam logic [7:0] LOW_LEVEL  = 8'(LOW_MARK);
  localparam logic [7:0] TIMER_LOAD = 8'(SEAL_CYC - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_CAP = 3'd1,
    PRESS    = 3'd2,
    DONE     = 3'd3,
    HOLD     = 3'd4
  } state_t;

  state_t     state_r;
  logic [7:0] timer_r;
  logic [7:0] cap_cnt_r;
  logic [7:0] seal_total_r;
  logic       ve_act_r;
  logic       ve_done_r;
  logic       refill_req_r;

  logic       dec_s;
  logic       ack_s;
  logic [7:0] cap_next_s;

  // Cap consumption on PRESS entry and magazine reload on an accepted ack
  always_comb begin
    dec_s      = 1'b0;
    ack_s      = refill_req_r & refill_ack;
    cap_next_s = cap_cnt_r;
    case (state_r)
      IDLE, WAIT_CAP: dec_s = pos_ve & (cap_cnt_r != 8'd0);
      default:        dec_s = 1'b0;
    endcase
    if (ack_s) begin
      // A reload coinciding with a PRESS entry still consumes that cap
      cap_next_s = CAP_FULL - {7'd0, dec_s};
    end else if (dec_s) begin
      cap_next_s = cap_cnt_r - 8'd1;
    end else begin
      cap_next_s = cap_cnt_r;
    end
  end

  // Sealing FSM, magazine counter and refill request, all with registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      timer_r      <= 8'd0;
      cap_cnt_r    <= CAP_FULL;
      seal_total_r <= 8'd0;
      ve_act_r     <= 1'b0;
      ve_done_r    <= 1'b0;
      refill_req_r <= 1'b0;
    end else begin
      cap_cnt_r <= cap_next_s;
      if (refill_req_r) begin
        refill_req_r <= ~refill_ack;
      end else begin
        refill_req_r <= cap_low;
      end

      case (state_r)
        IDLE, WAIT_CAP: begin
          ve_done_r <= 1'b0;
          if (!pos_ve) begin
            state_r  <= IDLE;
            ve_act_r <= 1'b0;
          end else if (dec_s) begin
            state_r  <= PRESS;
            timer_r  <= TIMER_LOAD;
            ve_act_r <= 1'b1;
          end else begin
            state_r  <= WAIT_CAP;
            ve_act_r <= 1'b0;
          end
        end
        PRESS: begin
          if (!pos_ve) begin
            // Abort: the consumed cap is deliberately not returned
            state_r   <= IDLE;
            ve_act_r  <= 1'b0;
            ve_done_r <= 1'b0;
          end else if (timer_r == 8'd0) begin
            state_r      <= DONE;
            ve_act_r     <= 1'b0;
            ve_done_r    <= 1'b1;
            seal_total_r <= seal_total_r + 8'd1;
          end else begin
            timer_r   <= timer_r - 8'd1;
            ve_act_r  <= 1'b1;
            ve_done_r <= 1'b0;
          end
        end
        DONE: begin
          state_r   <= HOLD;
          ve_act_r  <= 1'b0;
          ve_done_r <= 1'b0;
        end
        HOLD: begin
          ve_act_r  <= 1'b0;
          ve_done_r <= 1'b0;
          if (!pos_ve) begin
            state_r <= IDLE;
          end else begin
            state_r <= HOLD;
          end
        end
        default: begin
          state_r   <= IDLE;
          ve_act_r  <= 1'b0;
          ve_done_r <= 1'b0;
        end
      endcase
    end
  end

  assign ve_act     = ve_act_r;
  assign ve_done    = ve_done_r;
  assign refill_req = refill_req_r;
  assign cap_cnt    = cap_cnt_r;
  assign seal_total = seal_total_r;
  assign cap_low    = (cap_cnt_r <= LOW_LEVEL);
  assign cap_empty  = (cap_cnt_r == 8'd0);

endmodule
